// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared UART rates, pacing FSM states and gap helper
package uart_tx_fifo_pkg;
  localparam int UART_BPS_DEF = 115200;
  localparam int CLK_FREQ_DEF = 5000000;
  typedef enum logic [1:0] {
    TXF_IDLE   = 2'd0,
    TXF_LAUNCH = 2'd1,
    TXF_WAIT   = 2'd2
  } txf_state_t;
  function automatic int gap_clocks(int clk_freq, int bps, int frame_bits);
    return (clk_freq / bps) * frame_bits;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer write side and uart_tx launch side; flush_i exists under TXFIFO_FLUSH_EN
interface uart_tx_fifo_if #(parameter int AW = 4) ();
  import uart_tx_fifo_pkg::*;
  logic          wr_en_i;
  logic [7:0]    wr_data_i;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   level_o;
  logic          overflow_o;
  logic          busy_o;
  logic          txen;
  logic [7:0]    txpcdata;
`ifdef TXFIFO_FLUSH_EN
  logic          flush_i;
  modport master (output wr_en_i, wr_data_i, flush_i,
                  input full_o, empty_o, level_o, overflow_o, busy_o, txen, txpcdata);
  modport slave  (input wr_en_i, wr_data_i, flush_i,
                  output full_o, empty_o, level_o, overflow_o, busy_o, txen, txpcdata);
`else
  modport master (output wr_en_i, wr_data_i,
                  input full_o, empty_o, level_o, overflow_o, busy_o, txen, txpcdata);
  modport slave  (input wr_en_i, wr_data_i,
                  output full_o, empty_o, level_o, overflow_o, busy_o, txen, txpcdata);
`endif
endinterface

// File: rtl/uart_tx_fifo_sync_fifo8.sv
// sync_fifo8: DEPTH x 8 circular byte buffer with wrapping pointers and level tracking
module sync_fifo8
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign wr_ok   = wr_en & ~full & ~flush;
  assign rd_data = mem[rd_ptr];
  // storage array; contents need no reset since level gates every read
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= wr_data;
  // pointers wrap naturally at AW bits; level tracks push minus pop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_ok);
      rd_ptr <= rd_ptr + AW'(rd_en);
      level  <= level + (AW+1)'(wr_ok) - (AW+1)'(rd_en);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO pacing one-cycle launches to uart_tx one frame plus guard apart; optional flush via TXFIFO_FLUSH_EN
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int UART_BPS   = UART_BPS_DEF,
  parameter int FRAME_BITS = 11,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int GAP = gap_clocks(CLK_FREQ, UART_BPS, FRAME_BITS);
  localparam int CW  = $clog2(GAP) + 1;
  txf_state_t    state;
  logic [CW-1:0] cnt;
  logic          txen_q;
  logic [7:0]    txd_q;
  logic          overflow;
  logic          flush;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    rd_data;
  logic [AW:0]   level;
`ifdef TXFIFO_FLUSH_EN
  assign flush = bus.flush_i;
`else
  assign flush = 1'b0;
`endif
  assign pop = state == TXF_IDLE && !empty && !flush;
  sync_fifo8 #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (bus.wr_en_i),
    .wr_data (bus.wr_data_i),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.level_o    = level;
  assign bus.overflow_o = overflow;
  assign bus.busy_o     = state != TXF_IDLE || !empty;
  assign bus.txen       = txen_q;
  assign bus.txpcdata   = txd_q;
  // sticky record of any write attempted while full
  always_ff @(posedge clk or negedge rst)
    if (!rst) overflow <= 1'b0;
    else overflow <= !flush && (overflow || (bus.wr_en_i && full));
  // launch pacing: pop and pulse, then hold off GAP cycles since uart_tx has no busy
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= TXF_IDLE;
      cnt    <= '0;
      txen_q <= 1'b0;
      txd_q  <= 8'h00;
    end else begin
      case (state)
        TXF_IDLE: if (pop) begin
          txd_q  <= rd_data;
          txen_q <= 1'b1;
          state  <= TXF_LAUNCH;
        end
        TXF_LAUNCH: begin
          txen_q <= 1'b0;
          cnt    <= CW'(GAP - 1);
          state  <= TXF_WAIT;
        end
        TXF_WAIT: if (cnt == '0) state <= TXF_IDLE;
                  else cnt <= cnt - CW'(1);
        default: state <= TXF_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized scoreboard bench against a launch-schedule model of uart_tx_fifo
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int GAP   = (5000000 / 115200) * 11;
`ifdef TXFIFO_FLUSH_EN
  localparam bit HAS_FLUSH = 1'b1;
`else
  localparam bit HAS_FLUSH = 1'b0;
`endif
  typedef struct {
    int         en;
    logic [7:0] d;
  } launch_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.AW(AW)) bus ();
  uart_tx_fifo #(.CLK_FREQ(5000000), .UART_BPS(115200), .FRAME_BITS(11),
                 .DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] q[$];
  launch_t    exp_q[$];
  int         e = 0;
  int         next_ok = 0;
  int         passed = 0;
  int         total = 0;
  int         written = 0;
  bit         ovf = 1'b0;
  logic [7:0] last_d = 8'h00;

  task automatic chk(string name, int act, int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, e);
  endtask

  task automatic model_reset();
    q.delete();
    exp_q.delete();
    next_ok = 0;
    ovf = 1'b0;
    last_d = 8'h00;
  endtask

  // drive one cycle of inputs and advance the model to the state after the coming edge
  task automatic step(input bit we, input logic [7:0] d, input bit fl = 1'b0);
    bit f, do_pop, acc;
    launch_t l;
    @(negedge clk);
    bus.wr_en_i = we;
    bus.wr_data_i = d;
`ifdef TXFIFO_FLUSH_EN
    bus.flush_i = fl;
`endif
    f = fl & HAS_FLUSH;
    e++;
    do_pop = q.size() > 0 && e >= next_ok && !f;
    acc = we && q.size() < DEPTH && !f;
    if (we && q.size() == DEPTH) ovf = 1'b1;
    if (f) begin
      q.delete();
      ovf = 1'b0;
    end
    if (do_pop) begin
      l.en = e;
      l.d = q.pop_front();
      exp_q.push_back(l);
      next_ok = e + GAP + 2;
    end
    if (acc) begin
      q.push_back(d);
      written++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic drain();
    int b = 0;
    while ((q.size() > 0 || exp_q.size() > 0 || e < next_ok) && b < 40000) begin
      step(1'b0, 8'h00);
      b++;
    end
    @(posedge clk);
    #2;
    chk("drain_bound", int'(b < 40000), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_txen", bus.txen, 0);
    chk("rst_txpcdata", bus.txpcdata, 0);
    chk("rst_empty", bus.empty_o, 1);
    chk("rst_full", bus.full_o, 0);
    chk("rst_level", bus.level_o, 0);
    chk("rst_overflow", bus.overflow_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    model_reset();
    rst = 1'b1;
  endtask

  // monitor: compare every post-edge output against the model, popping the scoreboard on launches
  always @(posedge clk) begin
    bit now;
    #1;
    now = exp_q.size() > 0 && exp_q[0].en == e;
    chk("txen", bus.txen, now);
    if (now) begin
      last_d = exp_q[0].d;
      void'(exp_q.pop_front());
    end
    chk("txpcdata", bus.txpcdata, last_d);
    chk("level", bus.level_o, q.size());
    chk("full", bus.full_o, int'(q.size() == DEPTH));
    chk("empty", bus.empty_o, int'(q.size() == 0));
    chk("overflow", bus.overflow_o, ovf);
    chk("busy", bus.busy_o, int'(q.size() > 0 || e < next_ok - 1));
  end

  initial begin
    bus.wr_en_i = 1'b0;
    bus.wr_data_i = 8'h00;
`ifdef TXFIFO_FLUSH_EN
    bus.flush_i = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #4 rst = 1'b1;
    step(1'b1, 8'hA5);
    drain();
    step(1'b1, 8'hEE);
    idle(3);
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i));
    drain();
    do_reset();
    step(1'b1, 8'h10);
    idle(3);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
    while (e + 1 < next_ok) step(1'b0, 8'h00);
    step(1'b1, 8'h77);
    while (written < 45) begin
      idle($urandom_range(0, 600));
      repeat ($urandom_range(1, 8)) step(1'b1, 8'($urandom));
    end
    drain();
    step(1'b1, 8'h21);
    idle(3);
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom));
    idle(50);
    do_reset();
    idle(1000);
`ifdef TXFIFO_FLUSH_EN
    step(1'b1, 8'h31);
    idle(3);
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
    idle(20);
    step(1'b0, 8'h00, 1'b1);
    idle(2);
    step(1'b1, 8'h5A);
    drain();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
